// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two valid/ready requesters
//
// One operation is in flight at a time. The FSM runs IDLE -> EXEC -> RESP -> IDLE.
// The result is registered at the end of EXEC and returned only to the requester that issued it.
//
// Ports
//   clk, reset               rising-edge clock; asynchronous active-high reset
//   flush                    synchronous abort of the in-flight op (also blocks new accepts)
//   rN_valid/rN_ready        request handshake for requester N (0 = execute, 1 = branch/addr)
//   rN_a, rN_b, rN_func      operands and function select
//   rN_sub_sra               subtract / arithmetic-shift enable
//   rN_rsp_valid/ready       response handshake for requester N
//   rsp_val, rsp_flags       registered result and {EQ,LU,LS} (shared bus)
//   alu_a/b/func/sub_sra     to the shared ALU, always driven from the operand regs
//   alu_val, alu_eq/lu/ls    from the shared ALU
//
// Configuration
//   ALU_ARB_RR_EN  defined: round-robin between requesters (1-bit last-served pointer)
//                  undefined: fixed priority, r0 over r1
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [WIDTH-1:0]  r0_a,
    input  logic [WIDTH-1:0]  r0_b,
    input  logic [FUNC_W-1:0] r0_func,
    input  logic              r0_sub_sra,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [WIDTH-1:0]  r1_a,
    input  logic [WIDTH-1:0]  r1_b,
    input  logic [FUNC_W-1:0] r1_func,
    input  logic              r1_sub_sra,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [WIDTH-1:0]  rsp_val,
    output logic [2:0]        rsp_flags,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [FUNC_W-1:0] alu_func,
    output logic              alu_sub_sra,
    input  logic [WIDTH-1:0]  alu_val,
    input  logic              alu_eq,
    input  logic              alu_lu,
    input  logic              alu_ls
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state, state_nxt;
    logic                owner;
    logic                gnt1;
    logic                accept;
    logic [WIDTH-1:0]    a_q, b_q;
    logic [FUNC_W-1:0]   func_q;
    logic                sub_q;

`ifdef ALU_ARB_RR_EN
    logic last;

    // Under contention the requester that was not served last wins.
    assign gnt1 = r1_valid & (~r0_valid | ~last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= 1'b0;
        else if (accept)
            last <= gnt1;
    end
`else
    // r1 only wins when r0 has nothing to issue.
    assign gnt1 = ~r0_valid;
`endif

    assign accept = (r0_valid & r0_ready) | (r1_valid & r1_ready);

    always_comb begin
        state_nxt    = state;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Grant is exclusive; flush and reset both hold off new accepts.
                r0_ready  = ~flush & ~reset & ~gnt1;
                r1_ready  = ~flush & ~reset & gnt1;
                state_nxt = accept ? EXEC : IDLE;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                r0_rsp_valid = ~owner;
                r1_rsp_valid = owner;
                state_nxt    = (owner ? r1_rsp_ready : r0_rsp_ready) ? IDLE : RESP;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            func_q    <= '0;
            sub_q     <= 1'b0;
            owner     <= 1'b0;
            rsp_val   <= '0;
            rsp_flags <= '0;
        end else begin
            if (accept) begin
                a_q    <= gnt1 ? r1_a : r0_a;
                b_q    <= gnt1 ? r1_b : r0_b;
                func_q <= gnt1 ? r1_func : r0_func;
                sub_q  <= gnt1 ? r1_sub_sra : r0_sub_sra;
                owner  <= gnt1;
            end
            // A flushed op never reaches RESP, so its result is not captured.
            if (state == EXEC && !flush) begin
                rsp_val   <= alu_val;
                rsp_flags <= {alu_eq, alu_lu, alu_ls};
            end
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_func    = func_q;
    assign alu_sub_sra = sub_q;

endmodule
